// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, data port and shared memory bus seen by mem_port_arbiter.
// The slave modport is the arbiter's view; master is the core/memory side.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_stall;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        dm_stall;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        bus_err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, if_stall, dm_rdata, dm_ready, dm_stall,
               mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, if_stall, dm_rdata, dm_ready, dm_stall,
               mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store accesses onto one single-ported memory bus with a watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise the data port wins ties.
module mem_port_arbiter #(
    parameter int          TIMEOUT   = 64,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic              clk,
    input logic              reset,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    localparam logic [7:0] WDOG_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wdogCnt;
    logic       ifElig;
    logic       dmElig;
    logic       grantDm;
    logic       wdogExpire;

    // A port is masked during its own completion cycle so a held request is not re-serviced.
    assign ifElig = bus.if_req & ~bus.if_ready;
    assign dmElig = bus.dm_req & ~bus.dm_ready;

`ifdef ARB_ROUND_ROBIN_EN
    logic lastGrantDm;
    assign grantDm = dmElig & (~ifElig | ~lastGrantDm);
`else
    assign grantDm = dmElig;
`endif

    assign wdogExpire = (TIMEOUT != 0) && (wdogCnt == WDOG_LAST);

    assign bus.if_stall = bus.if_req & ~bus.if_ready;
    assign bus.dm_stall = bus.dm_req & ~bus.dm_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wdogCnt       <= 8'd0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'd0;
            bus.mem_wdata <= 32'd0;
            bus.if_rdata  <= 32'd0;
            bus.dm_rdata  <= 32'd0;
            bus.if_ready  <= 1'b0;
            bus.dm_ready  <= 1'b0;
            bus.bus_err   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            lastGrantDm   <= 1'b0;
`endif
        end else begin
            bus.if_ready <= 1'b0;
            bus.dm_ready <= 1'b0;
            bus.bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (ifElig | dmElig) begin
                        bus.mem_req <= 1'b1;
                        wdogCnt     <= 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
                        lastGrantDm <= grantDm;
`endif
                        if (grantDm) begin
                            bus.mem_we    <= bus.dm_we;
                            bus.mem_addr  <= bus.dm_addr;
                            bus.mem_wdata <= bus.dm_wdata;
                            state         <= BUSY_DM;
                        end else begin
                            bus.mem_we   <= 1'b0;
                            bus.mem_addr <= bus.if_addr;
                            state        <= BUSY_IF;
                        end
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    // An ack in the final watchdog cycle still completes normally.
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        state       <= IDLE;
                        if (state == BUSY_IF) begin
                            bus.if_rdata <= bus.mem_rdata;
                            bus.if_ready <= 1'b1;
                        end else begin
                            bus.dm_rdata <= bus.mem_rdata;
                            bus.dm_ready <= 1'b1;
                        end
                    end else if (wdogExpire) begin
                        bus.mem_req <= 1'b0;
                        bus.bus_err <= 1'b1;
                        state       <= IDLE;
                        if (state == BUSY_IF) begin
                            bus.if_rdata <= NOP_INSTR;
                            bus.if_ready <= 1'b1;
                        end else begin
                            bus.dm_rdata <= 32'd0;
                            bus.dm_ready <= 1'b1;
                        end
                    end else begin
                        wdogCnt <= wdogCnt + 8'd1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected bus requests and responses,
// a negedge process models the memory and checks every ready pulse against the queues.
module tb_mem_port_arbiter;
    localparam int TO = 4;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          ackDelay;
    } memExp_t;

    typedef struct {
        logic        isDm;
        logic [31:0] rdata;
        logic        chkData;
        logic        err;
        int          len;
    } respExp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.TIMEOUT(TO), .NOP_INSTR(32'h0000_0013)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    memExp_t     memQ[$];
    respExp_t    respQ[$];
    logic [31:0] wrMem [logic [31:0]];
    memExp_t     cur;
    int          busyCyc  = 0;
    logic        forceAck = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] presetData(input logic [31:0] a);
        case (a)
            32'h0000_0010: return 32'h0050_0093;
            32'h0000_0020: return 32'h1111_2222;
            32'h0000_0200: return 32'h3333_4444;
            default:       return 32'h0;
        endcase
    endfunction

    function automatic void checkResp(input logic isDm);
        respExp_t e;
        logic [31:0] act;
        act = isDm ? bus.dm_rdata : bus.if_rdata;
        if (respQ.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ready: got ready on port dm=%0d expected none", isDm);
            return;
        end
        e = respQ.pop_front();
        chk("resp_port_is_dm", {31'd0, isDm}, {31'd0, e.isDm});
        if (e.chkData) chk(isDm ? "dm_rdata" : "if_rdata", act, e.rdata);
        chk("bus_err_on_ready", {31'd0, bus.bus_err}, {31'd0, e.err});
        chk("mem_req_cycles", busyCyc, e.len);
    endfunction

    // Memory model and response monitor share one negedge process so ordering is fixed.
    always @(negedge clk) begin
        if (reset) begin
            busyCyc       = 0;
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'h0;
        end else begin
            chk("if_stall", {31'd0, bus.if_stall}, {31'd0, bus.if_req & ~bus.if_ready});
            chk("dm_stall", {31'd0, bus.dm_stall}, {31'd0, bus.dm_req & ~bus.dm_ready});
            chk("bus_err_without_ready", {31'd0, bus.bus_err & ~(bus.if_ready | bus.dm_ready)}, 32'd0);
            if (bus.if_ready) checkResp(1'b0);
            if (bus.dm_ready) checkResp(1'b1);

            bus.mem_ack   = forceAck;
            bus.mem_rdata = 32'hBAD0_BAD0;
            if (bus.mem_req) begin
                if (busyCyc == 0) begin
                    if (memQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_mem_req: got addr %h expected no request", bus.mem_addr);
                        cur = '{addr: bus.mem_addr, we: bus.mem_we, wdata: bus.mem_wdata, ackDelay: 0};
                    end else begin
                        cur = memQ.pop_front();
                    end
                end
                chk("mem_addr", bus.mem_addr, cur.addr);
                chk("mem_we", {31'd0, bus.mem_we}, {31'd0, cur.we});
                if (cur.we) chk("mem_wdata", bus.mem_wdata, cur.wdata);
                if (cur.ackDelay == busyCyc) begin
                    bus.mem_ack = 1'b1;
                    if (bus.mem_we) wrMem[bus.mem_addr] = bus.mem_wdata;
                    bus.mem_rdata = wrMem.exists(bus.mem_addr) ? wrMem[bus.mem_addr]
                                                              : presetData(bus.mem_addr);
                end
                busyCyc++;
            end else begin
                busyCyc = 0;
            end
        end
    end

    task automatic pushMem(input logic [31:0] a, input logic we, input logic [31:0] d, input int dly);
        memQ.push_back('{addr: a, we: we, wdata: d, ackDelay: dly});
    endtask

    task automatic pushResp(input logic isDm, input logic [31:0] rd, input logic cd, input logic err, input int len);
        respQ.push_back('{isDm: isDm, rdata: rd, chkData: cd, err: err, len: len});
    endtask

    task automatic ifAccess(input logic [31:0] a, input bit dropEarly);
        int n;
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        if (dropEarly) begin
            @(posedge clk);
            #1 bus.if_req = 1'b0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.if_ready && n < 40);
        if (!bus.if_ready) begin
            checks++;
            failures++;
            $display("FAIL if_wait: got no if_ready after %0d cycles expected a pulse", n);
        end
        @(posedge clk);
        #1 bus.if_req = 1'b0;
    endtask

    task automatic dmAccess(input logic we, input logic [31:0] a, input logic [31:0] d);
        int n;
        bus.dm_req   = 1'b1;
        bus.dm_we    = we;
        bus.dm_addr  = a;
        bus.dm_wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.dm_ready && n < 40);
        if (!bus.dm_ready) begin
            checks++;
            failures++;
            $display("FAIL dm_wait: got no dm_ready after %0d cycles expected a pulse", n);
        end
        @(posedge clk);
        #1 bus.dm_req = 1'b0;
    endtask

    task automatic checkResetVals(input string nm);
        chk({nm, "_mem_req"},   {31'd0, bus.mem_req},  32'd0);
        chk({nm, "_mem_we"},    {31'd0, bus.mem_we},   32'd0);
        chk({nm, "_mem_addr"},  bus.mem_addr,          32'd0);
        chk({nm, "_mem_wdata"}, bus.mem_wdata,         32'd0);
        chk({nm, "_if_ready"},  {31'd0, bus.if_ready}, 32'd0);
        chk({nm, "_dm_ready"},  {31'd0, bus.dm_ready}, 32'd0);
        chk({nm, "_bus_err"},   {31'd0, bus.bus_err},  32'd0);
        chk({nm, "_if_rdata"},  bus.if_rdata,          32'd0);
        chk({nm, "_dm_rdata"},  bus.dm_rdata,          32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset        = 1'b1;
        bus.if_req   = 1'b0;
        bus.if_addr  = 32'h0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = 32'h0;
        bus.dm_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkResetVals("por");

        // Fetch only, ack on first mem_req cycle.
        @(posedge clk); #1;
        pushMem(32'h10, 1'b0, 32'h0, 0);
        pushResp(1'b0, 32'h0050_0093, 1'b1, 1'b0, 1);
        ifAccess(32'h10, 1'b0);

        // Store with ack in the last cycle before the watchdog would fire.
        pushMem(32'h100, 1'b1, 32'hDEAD_BEEF, 3);
        pushResp(1'b1, 32'h0, 1'b0, 1'b0, 4);
        dmAccess(1'b1, 32'h100, 32'hDEAD_BEEF);

        // Load back the stored word.
        pushMem(32'h100, 1'b0, 32'h0, 1);
        pushResp(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 2);
        dmAccess(1'b0, 32'h100, 32'h0);

        // Tie after two DM grants: round-robin picks IF, fixed priority picks DM.
`ifdef ARB_ROUND_ROBIN_EN
        pushMem(32'h20, 1'b0, 32'h0, 0);
        pushResp(1'b0, 32'h1111_2222, 1'b1, 1'b0, 1);
        pushMem(32'h200, 1'b0, 32'h0, 0);
        pushResp(1'b1, 32'h3333_4444, 1'b1, 1'b0, 1);
`else
        pushMem(32'h200, 1'b0, 32'h0, 0);
        pushResp(1'b1, 32'h3333_4444, 1'b1, 1'b0, 1);
        pushMem(32'h20, 1'b0, 32'h0, 0);
        pushResp(1'b0, 32'h1111_2222, 1'b1, 1'b0, 1);
`endif
        fork
            ifAccess(32'h20, 1'b0);
            dmAccess(1'b0, 32'h200, 32'h0);
        join

        // Fetch with no ack: watchdog abort after TO cycles returns a NOP.
        pushMem(32'h30, 1'b0, 32'h0, -1);
        pushResp(1'b0, 32'h0000_0013, 1'b1, 1'b1, TO);
        ifAccess(32'h30, 1'b0);

        // Requester drops if_req right after the grant; access still completes once.
        pushMem(32'h10, 1'b0, 32'h0, 2);
        pushResp(1'b0, 32'h0050_0093, 1'b1, 1'b0, 3);
        ifAccess(32'h10, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // Reset in the middle of a store, followed by a stray ack.
        pushMem(32'h140, 1'b1, 32'hCAFE_F00D, 20);
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 32'h140;
        bus.dm_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 reset = 1'b1;
        bus.dm_req = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        forceAck = 1'b1;
        @(negedge clk);
        checkResetVals("mid_reset");
        @(posedge clk);
        #1 forceAck = 1'b0;
        @(negedge clk);
        checkResetVals("late_ack");

        // Tie right after reset goes to DM under either policy.
        @(posedge clk); #1;
        pushMem(32'h100, 1'b0, 32'h0, 1);
        pushResp(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 2);
        pushMem(32'h20, 1'b0, 32'h0, 0);
        pushResp(1'b0, 32'h1111_2222, 1'b1, 1'b0, 1);
        fork
            ifAccess(32'h20, 1'b0);
            dmAccess(1'b0, 32'h100, 32'h0);
        join

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("resp_queue_drained", respQ.size(), 32'd0);
        chk("mem_queue_drained", memQ.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
